// File: rtl/qracc_sram_port_arbiter.sv
// qracc_sram_port_arbiter
//
// Purpose:
//   Shares the single QRAcc SRAM request port between two requesters.
//   Requester 0 is the host bus path and requester 1 is the internal weight
//   loader. Arbitration is round-robin with one outstanding transaction at a
//   time. Read data is returned to the requester that issued the read. A
//   per-requester lock lets the owner keep the port for back-to-back bursts.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid_i[2]    per-requester request valid
//   req_ready_o[2]    per-requester accept (transfer on valid & ready)
//   req_wr_i[2]       1 = write, 0 = read
//   req_addr_i        packed addresses, requester r at [r*AW +: AW]
//   req_wdata_i       packed write data, requester r at [r*NUM_COLS +: NUM_COLS]
//   req_lock_i[2]     keep the grant after the current transaction
//   rsp_valid_o[2]    one-cycle read-data-valid pulse per requester
//   rsp_data_o        shared read data bus, qualified by rsp_valid_o
//   sram_*            request/response handshake with the SRAM macro wrapper
//   grant_o           index of the current owner, meaningful while busy_o
//   busy_o            arbiter is not idle

module qracc_sram_port_arbiter #(
  parameter  int NUM_ROWS = 128,
  parameter  int NUM_COLS = 32,
  localparam int AW       = $clog2(NUM_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_wr_i,
  input  logic [2*AW-1:0]       req_addr_i,
  input  logic [2*NUM_COLS-1:0] req_wdata_i,
  input  logic [1:0]            req_lock_i,
  output logic [1:0]            rsp_valid_o,
  output logic [NUM_COLS-1:0]   rsp_data_o,
  output logic                  sram_rq_valid_o,
  output logic                  sram_rq_wr_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [NUM_COLS-1:0]   sram_wr_data_o,
  input  logic                  sram_rq_ready_i,
  input  logic                  sram_rd_valid_i,
  input  logic [NUM_COLS-1:0]   sram_rd_data_i,
  output logic                  grant_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_grant;
  logic                r_last_grant;
  logic [1:0]          r_rsp_valid;
  logic [NUM_COLS-1:0] r_rsp_data;

  logic                w_issue;
  logic                w_sel_valid;
  logic                w_sel_wr;
  logic                w_sel_lock;
  logic [AW-1:0]       w_sel_addr;
  logic [NUM_COLS-1:0] w_sel_wdata;
  logic                w_accept;
  logic                w_next_grant;

  // Fields of whichever requester currently owns the port.
  assign w_sel_valid = r_grant ? req_valid_i[1] : req_valid_i[0];
  assign w_sel_wr    = r_grant ? req_wr_i[1]    : req_wr_i[0];
  assign w_sel_lock  = r_grant ? req_lock_i[1]  : req_lock_i[0];
  assign w_sel_addr  = r_grant ? req_addr_i[2*AW-1:AW] : req_addr_i[AW-1:0];
  assign w_sel_wdata = r_grant ? req_wdata_i[2*NUM_COLS-1:NUM_COLS]
                               : req_wdata_i[NUM_COLS-1:0];

  // A lone requester wins outright; on a tie the one not served last wins.
  assign w_next_grant = (req_valid_i == 2'b11) ? ~r_last_grant : req_valid_i[1];

  // The SRAM port is only driven in S_ISSUE; everywhere else it is held at 0
  // so the macro never sees a stray request.
  assign w_issue         = (r_state == S_ISSUE);
  assign sram_rq_valid_o = w_issue & w_sel_valid;
  assign sram_rq_wr_o    = w_issue & w_sel_wr;
  assign sram_addr_o     = w_issue ? w_sel_addr  : '0;
  assign sram_wr_data_o  = w_issue ? w_sel_wdata : '0;
  assign w_accept        = sram_rq_valid_o & sram_rq_ready_i;

  // SRAM readiness is forwarded only to the owner.
  always_comb begin
    req_ready_o = 2'b00;
    if (w_issue) begin
      if (r_grant) req_ready_o = {sram_rq_ready_i, 1'b0};
      else         req_ready_o = {1'b0, sram_rq_ready_i};
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state != S_IDLE);

  // Arbitration FSM. A finished transaction re-enters S_ISSUE directly when
  // the owner holds its lock, which skips the arbitration cycle and allows
  // one locked write per clock. last_grant only moves on an accepted request,
  // so a requester that withdraws does not lose its turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 2'b00;
      r_rsp_data   <= '0;
    end else begin
      r_rsp_valid <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|req_valid_i) begin
            r_grant <= w_next_grant;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_last_grant <= r_grant;
            if (w_sel_wr) r_state <= w_sel_lock ? S_ISSUE : S_IDLE;
            else          r_state <= S_WAIT_RD;
          end else if (!w_sel_valid) begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT_RD: begin
          if (sram_rd_valid_i) begin
            r_rsp_data  <= sram_rd_data_i;
            r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
            r_state     <= w_sel_lock ? S_ISSUE : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qracc_sram_port_arbiter.sv
// tb_qracc_sram_port_arbiter
//
// Purpose:
//   Self-checking bench for qracc_sram_port_arbiter. Each record holds one
//   clock cycle of inputs and the outputs expected in that cycle. Inputs are
//   driven on the falling edge and outputs sampled 1 ns later, so the check
//   sees the state left by the previous rising edge.

module tb_qracc_sram_port_arbiter;

  localparam int NUM_ROWS = 128;
  localparam int NUM_COLS = 32;
  localparam int AW       = $clog2(NUM_ROWS);

  logic                  clk;
  logic                  rst;
  logic [1:0]            req_valid_i;
  logic [1:0]            req_ready_o;
  logic [1:0]            req_wr_i;
  logic [2*AW-1:0]       req_addr_i;
  logic [2*NUM_COLS-1:0] req_wdata_i;
  logic [1:0]            req_lock_i;
  logic [1:0]            rsp_valid_o;
  logic [NUM_COLS-1:0]   rsp_data_o;
  logic                  sram_rq_valid_o;
  logic                  sram_rq_wr_o;
  logic [AW-1:0]         sram_addr_o;
  logic [NUM_COLS-1:0]   sram_wr_data_o;
  logic                  sram_rq_ready_i;
  logic                  sram_rd_valid_i;
  logic [NUM_COLS-1:0]   sram_rd_data_i;
  logic                  grant_o;
  logic                  busy_o;

  int errCount   = 0;
  int checkCount = 0;

  qracc_sram_port_arbiter #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_wr_i        (req_wr_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .req_lock_i      (req_lock_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_data_o      (rsp_data_o),
    .sram_rq_valid_o (sram_rq_valid_o),
    .sram_rq_wr_o    (sram_rq_wr_o),
    .sram_addr_o     (sram_addr_o),
    .sram_wr_data_o  (sram_wr_data_o),
    .sram_rq_ready_i (sram_rq_ready_i),
    .sram_rd_valid_i (sram_rd_valid_i),
    .sram_rd_data_i  (sram_rd_data_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rst;
    logic [1:0]    valid;
    logic [1:0]    wr;
    logic [1:0]    lock;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [31:0]   wd0;
    logic [31:0]   wd1;
    logic          sramReady;
    logic          rdValid;
    logic [31:0]   rdData;
    logic [1:0]    eReady;
    logic          eSValid;
    logic          eSWr;
    logic [AW-1:0] eSAddr;
    logic [31:0]   eSData;
    logic [1:0]    eRspValid;
    logic [31:0]   eRspData;
    logic          eGrant;
    logic          eBusy;
  } vec_t;

  // Builds one cycle record: inputs first, then expected outputs.
  function automatic vec_t mk(
    input string n, input logic r, input logic [1:0] v, input logic [1:0] w,
    input logic [1:0] lk, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
    input logic [31:0] d0, input logic [31:0] d1, input logic sr, input logic rv,
    input logic [31:0] rd, input logic [1:0] eRdy, input logic eSV, input logic eSW,
    input logic [AW-1:0] eSA, input logic [31:0] eSD, input logic [1:0] eRV,
    input logic [31:0] eRD, input logic eG, input logic eB);
    vec_t t;
    t.name = n; t.rst = r; t.valid = v; t.wr = w; t.lock = lk;
    t.addr0 = a0; t.addr1 = a1; t.wd0 = d0; t.wd1 = d1;
    t.sramReady = sr; t.rdValid = rv; t.rdData = rd;
    t.eReady = eRdy; t.eSValid = eSV; t.eSWr = eSW; t.eSAddr = eSA; t.eSData = eSD;
    t.eRspValid = eRV; t.eRspData = eRD; t.eGrant = eG; t.eBusy = eB;
    return t;
  endfunction

  // Drives one cycle of inputs on the falling edge.
  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    rst             = t.rst;
    req_valid_i     = t.valid;
    req_wr_i        = t.wr;
    req_lock_i      = t.lock;
    req_addr_i      = {t.addr1, t.addr0};
    req_wdata_i     = {t.wd1, t.wd0};
    sram_rq_ready_i = t.sramReady;
    sram_rd_valid_i = t.rdValid;
    sram_rd_data_i  = t.rdData;
  endtask

  // Compares every output against the record, 1 ns after the inputs settle.
  task automatic checkOutput(input vec_t t);
    logic [78:0] act;
    logic [78:0] exp;
    #1;
    act = {req_ready_o, sram_rq_valid_o, sram_rq_wr_o, sram_addr_o, sram_wr_data_o,
           rsp_valid_o, rsp_data_o, grant_o, busy_o};
    exp = {t.eReady, t.eSValid, t.eSWr, t.eSAddr, t.eSData,
           t.eRspValid, t.eRspData, t.eGrant, t.eBusy};
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got rdy=%b sv=%b sw=%b sa=%0d sd=%h rv=%b rd=%h g=%b b=%b, want rdy=%b sv=%b sw=%b sa=%0d sd=%h rv=%b rd=%h g=%b b=%b",
               t.name, req_ready_o, sram_rq_valid_o, sram_rq_wr_o, sram_addr_o, sram_wr_data_o,
               rsp_valid_o, rsp_data_o, grant_o, busy_o,
               t.eReady, t.eSValid, t.eSWr, t.eSAddr, t.eSData,
               t.eRspValid, t.eRspData, t.eGrant, t.eBusy);
    end
  endtask

  task automatic runVec(input vec_t t);
    applyStimulus(t);
    checkOutput(t);
  endtask

  localparam logic [31:0] RD  = 32'h12345678;
  localparam logic [31:0] DB  = 32'hDEADBEEF;
  localparam logic [31:0] A0  = 32'h000000A0;
  localparam logic [31:0] B1  = 32'h000000B1;
  localparam logic [31:0] C0  = 32'h000000C0;
  localparam logic [31:0] SD  = 32'h55AA55AA;

  vec_t vecs[$];

  initial begin
    // Hold reset for two edges before the table starts.
    rst = 1'b1; req_valid_i = '0; req_wr_i = '0; req_lock_i = '0;
    req_addr_i = '0; req_wdata_i = '0; sram_rq_ready_i = 1'b0;
    sram_rd_valid_i = 1'b0; sram_rd_data_i = '0;
    repeat (2) @(posedge clk);

    //              name        rst valid  wr     lock a0 a1 wd0 wd1 srdy rdv rdData   eRdy  eSV eSW eSA eSD eRV    eRD eG eB
    vecs.push_back(mk("reset",    1, 2'b00, 2'b00, 2'b00, 0, 0, 0,  0,  0, 0, 0,       2'b00, 0, 0, 0, 0,  2'b00, 0,  0, 0));
    // Single write from requester 0.
    vecs.push_back(mk("wr_idle",  0, 2'b01, 2'b01, 2'b00, 5, 0, DB, 0,  1, 0, 0,       2'b00, 0, 0, 0, 0,  2'b00, 0,  0, 0));
    vecs.push_back(mk("wr_issue", 0, 2'b01, 2'b01, 2'b00, 5, 0, DB, 0,  1, 0, 0,       2'b01, 1, 1, 5, DB, 2'b00, 0,  0, 1));
    vecs.push_back(mk("wr_done",  0, 2'b00, 2'b00, 2'b00, 0, 0, 0,  0,  1, 0, 0,       2'b00, 0, 0, 0, 0,  2'b00, 0,  0, 0));
    // Read from requester 1, SRAM answers two cycles after the accept.
    vecs.push_back(mk("rd_idle",  0, 2'b10, 2'b00, 2'b00, 0, 7, 0,  0,  1, 0, 0,       2'b00, 0, 0, 0, 0,  2'b00, 0,  0, 0));
    vecs.push_back(mk("rd_issue", 0, 2'b10, 2'b00, 2'b00, 0, 7, 0,  0,  1, 0, 0,       2'b10, 1, 0, 7, 0,  2'b00, 0,  1, 1));
    vecs.push_back(mk("rd_wait1", 0, 2'b00, 2'b00, 2'b00, 0, 0, 0,  0,  1, 0, 0,       2'b00, 0, 0, 0, 0,  2'b00, 0,  1, 1));
    vecs.push_back(mk("rd_wait2", 0, 2'b00, 2'b00, 2'b00, 0, 0, 0,  0,  1, 1, RD,      2'b00, 0, 0, 0, 0,  2'b00, 0,  1, 1));
    vecs.push_back(mk("rd_rsp",   0, 2'b00, 2'b00, 2'b00, 0, 0, 0,  0,  1, 0, 0,       2'b00, 0, 0, 0, 0,  2'b10, RD, 1, 0));
    vecs.push_back(mk("rd_hold",  0, 2'b00, 2'b00, 2'b00, 0, 0, 0,  0,  1, 0, 0,       2'b00, 0, 0, 0, 0,  2'b00, RD, 1, 0));
    // Both write continuously: grants alternate with an idle cycle between.
    vecs.push_back(mk("rr_idle0", 0, 2'b11, 2'b11, 2'b00, 1, 2, A0, B1, 1, 0, 0,       2'b00, 0, 0, 0, 0,  2'b00, RD, 1, 0));
    vecs.push_back(mk("rr_g0",    0, 2'b11, 2'b11, 2'b00, 1, 2, A0, B1, 1, 0, 0,       2'b01, 1, 1, 1, A0, 2'b00, RD, 0, 1));
    vecs.push_back(mk("rr_idle1", 0, 2'b11, 2'b11, 2'b00, 1, 2, A0, B1, 1, 0, 0,       2'b00, 0, 0, 0, 0,  2'b00, RD, 0, 0));
    vecs.push_back(mk("rr_g1",    0, 2'b11, 2'b11, 2'b00, 1, 2, A0, B1, 1, 0, 0,       2'b10, 1, 1, 2, B1, 2'b00, RD, 1, 1));
    vecs.push_back(mk("rr_idle2", 0, 2'b11, 2'b11, 2'b00, 1, 2, A0, B1, 1, 0, 0,       2'b00, 0, 0, 0, 0,  2'b00, RD, 1, 0));
    vecs.push_back(mk("rr_g0b",   0, 2'b11, 2'b11, 2'b00, 1, 2, A0, B1, 1, 0, 0,       2'b01, 1, 1, 1, A0, 2'b00, RD, 0, 1));
    vecs.push_back(mk("rr_quiet", 0, 2'b00, 2'b00, 2'b00, 0, 0, 0,  0,  1, 0, 0,       2'b00, 0, 0, 0, 0,  2'b00, RD, 0, 0));

    foreach (vecs[i]) runVec(vecs[i]);

    // Locked burst: requester 1 holds the port for four writes while
    // requester 0 waits; last_grant is 0 so requester 1 wins the tie.
    runVec(mk("lock_idle", 0, 2'b11, 2'b11, 2'b10, 9, 0, C0, 32'hD0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, RD, 0, 0));
    for (int k = 0; k < 4; k++) begin
      runVec(mk($sformatf("lock_w%0d", k), 0, 2'b11, 2'b11, (k < 3) ? 2'b10 : 2'b00,
                9, AW'(k), C0, 32'hD0 + k, 1, 0, 0,
                2'b10, 1, 1, AW'(k), 32'hD0 + k, 2'b00, RD, 1, 1));
    end
    runVec(mk("lock_rel",  0, 2'b11, 2'b11, 2'b00, 9, 0, C0, 32'hD0, 1, 0, 0, 2'b00, 0, 0, 0, 0,  2'b00, RD, 1, 0));
    runVec(mk("lock_g0",   0, 2'b11, 2'b11, 2'b00, 9, 0, C0, 32'hD0, 1, 0, 0, 2'b01, 1, 1, 9, C0, 2'b00, RD, 0, 1));
    runVec(mk("lock_end",  0, 2'b00, 2'b00, 2'b00, 0, 0, 0,  0,      1, 0, 0, 2'b00, 0, 0, 0, 0,  2'b00, RD, 0, 0));

    // Stalled SRAM: request and fields stay put for five cycles, ready only
    // appears on the accepting cycle.
    runVec(mk("stall_idle", 0, 2'b01, 2'b01, 2'b00, 7'h11, 0, SD, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, RD, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      runVec(mk($sformatf("stall_c%0d", k), 0, 2'b01, 2'b01, 2'b00, 7'h11, 0, SD, 0, 0, 0, 0,
                2'b00, 1, 1, 7'h11, SD, 2'b00, RD, 0, 1));
    end
    runVec(mk("stall_acc",  0, 2'b01, 2'b01, 2'b00, 7'h11, 0, SD, 0, 1, 0, 0, 2'b01, 1, 1, 7'h11, SD, 2'b00, RD, 0, 1));
    runVec(mk("stall_end",  0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0,     1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, RD, 0, 0));

    // Reset during S_WAIT_RD: no response, late rd_valid ignored, and the
    // following tie goes to requester 0 again.
    runVec(mk("rst_idle",  0, 2'b01, 2'b00, 2'b00, 3, 0, 0, 0, 1, 0, 0,            2'b00, 0, 0, 0, 0, 2'b00, RD, 0, 0));
    runVec(mk("rst_issue", 0, 2'b01, 2'b00, 2'b00, 3, 0, 0, 0, 1, 0, 0,            2'b01, 1, 0, 3, 0, 2'b00, RD, 0, 1));
    runVec(mk("rst_wait",  0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0,            2'b00, 0, 0, 0, 0, 2'b00, RD, 0, 1));
    runVec(mk("rst_assert",1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0,            2'b00, 0, 0, 0, 0, 2'b00, RD, 0, 1));
    runVec(mk("rst_late",  0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 32'hFFFF0000, 2'b00, 0, 0, 0, 0, 2'b00, 0,  0, 0));
    runVec(mk("rst_noresp",0, 2'b11, 2'b11, 2'b00, 4, 6, 32'h11111111, 32'h22222222, 1, 0, 0,
              2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    runVec(mk("rst_tie0",  0, 2'b11, 2'b11, 2'b00, 4, 6, 32'h11111111, 32'h22222222, 1, 0, 0,
              2'b01, 1, 1, 4, 32'h11111111, 2'b00, 0, 0, 1));
    runVec(mk("rst_end",   0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0,            2'b00, 0, 0, 0, 0, 2'b00, 0,  0, 0));

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
